inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch stage of the three-stage pipeline, directly upstream of instruction decode. It owns the program counter and issues single-outstanding word requests to instruction memory. It registers each returned word with its PC into the IF/ID register that drives the decoder's `instruction` input. It honours decode back-pressure (`stall`) and branch/jump redirects from execute, discarding wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  byte address of the requested word, always word-aligned.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_rsp_valid`  in  1  response word valid, one cycle pulse.
- `imem_rsp_data`  in  32  instruction word.
- `stall`  in  1  decode cannot accept a new instruction; hold IF/ID.
- `redirect_valid`  in  1  execute resolved a taken branch/jump.
- `redirect_pc`  in  32  target address.
- `if_valid`  out  1  IF/ID register holds a valid instruction.
- `if_instruction`  out  32  instruction to decode.
- `if_pc`  out  32  address of `if_instruction`.
- `fetch_misaligned`  out  1  one-cycle pulse: redirect target had [1:0]≠0.

## Operation
- One clock, one reset. Reset is asynchronous and active-low.
- Registers: `pc_q`, `req_pc_q`, `drop_q`, `hold_q` (32b buffer), the IF/ID output registers, and a 3-state FSM.
- FSM states:
  - **REQ**: `imem_req_valid`=1 and `imem_req_addr`=`pc_q`. On `valid&ready`: `req_pc_q`←`pc_q`, `pc_q`←`pc_q`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to WAIT.
  - **WAIT**: `imem_req_valid`=0. On `imem_rsp_valid`:
    - if `drop_q`, discard the word, clear `drop_q`, go to REQ;
    - else if the IF/ID register is free (`!if_valid | !stall`), load `if_instruction`←rsp, `if_pc`←`req_pc_q`, `if_valid`←1, go to REQ;
    - else `hold_q`←rsp, go to HOLD.
  - **HOLD**: no request. When `!stall`, load IF/ID from `hold_q`/`req_pc_q`, go to REQ.
- IF/ID register: when `!stall` and nothing is loaded this cycle, `if_valid`←0. While `stall`, all IF/ID outputs hold.
- Redirect has highest priority and overrides `stall`:
  - `pc_q`←{`redirect_pc`[31:2],2'b00}; `if_valid`←0; `hold_q` is discarded.
  - From REQ with a handshake in the same cycle: go to WAIT with `drop_q`=1.
  - From REQ without a handshake: stay in REQ.
  - From WAIT with no response this cycle: stay in WAIT, `drop_q`=1.
  - From WAIT with a response this cycle: discard the response, go to REQ.
  - From HOLD: go to REQ.
  - `fetch_misaligned`=1 the following cycle if `redirect_pc`[1:0]≠0.
- `imem_rsp_valid` in REQ or HOLD is unsolicited and ignored.

## Timing
- Reset values: `pc_q`=`RESET_PC`, FSM=REQ, `drop_q`=0, `imem_req_valid`=1 from the first cycle after reset release, `imem_req_addr`=`RESET_PC`, `if_valid`=0, `if_instruction`=0, `if_pc`=0, `fetch_misaligned`=0.
- Response arrives ≥1 cycle after request acceptance. Memory returns words in order, one per request.
- Latency: response at edge N appears on `if_*` after edge N (registered).
- Best-case throughput is 1 instruction per 2 cycles (REQ, WAIT). At most one request is outstanding.
- Reset mid-operation clears all state immediately. A response arriving after reset release is ignored (FSM is in REQ).
- `imem_req_addr` is stable while `imem_req_valid`=1 and ready=0, unless a redirect occurs; a redirect may change the address.

## Test plan
- Reset, `RESET_PC`=0, memory with ready=1 and 1-cycle response → `if_pc` sequence 0,4,8,… with `if_valid` high every other cycle; `if_instruction` matches memory.
- `stall` held 5 cycles while a response returns → word goes to HOLD, `if_*` frozen, no new request. After release, the held word at PC 8 appears, then fetch resumes at 12.
- Redirect to 0x100 in the same cycle as request acceptance for PC 0x20 → the 0x20 response is dropped and never reaches `if_valid`. The next request address is 0x100.
- Redirect to 0x203 → next request 0x200 and `fetch_misaligned` pulses once.
- `pc_q`=32'hFFFF_FFFC fetched → next request address 0. `reset_n` asserted during WAIT → `if_valid`=0 immediately, and a late response is ignored.

Source files
------------

// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_if
//  Description : Instruction-memory request/response bus between the fetch
//                stage (master) and instruction memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch
//  Description : Instruction fetch stage. Owns the PC, issues one outstanding
//                word request at a time, registers returned words into the
//                IF/ID register, honours decode stall and execute redirects
//                (discarding wrong-path responses).
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    inst_fetch_if.master     imem,
    input  wire logic        stall,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    output logic             if_valid,
    output logic [31:0]      if_instruction,
    output logic [31:0]      if_pc,
    output logic             fetch_misaligned
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        drop_q;
    logic [31:0] hold_q;
    logic        if_valid_q;
    logic [31:0] if_instruction_q;
    logic [31:0] if_pc_q;
    logic        misaligned_q;

    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_ifid_free;
    logic [31:0] w_pc_inc;
    logic [31:0] w_redirect_aligned;

    // Request is a pure decode of the state flop; address is the PC flop.
    assign w_req_valid        = (state_q == S_REQ);
    assign w_req_fire         = w_req_valid & imem.imem_req_ready;
    assign w_ifid_free        = ~if_valid_q | ~stall;
    assign w_pc_inc           = pc_q + 32'd4;
    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = pc_q;

    assign if_valid         = if_valid_q;
    assign if_instruction   = if_instruction_q;
    assign if_pc            = if_pc_q;
    assign fetch_misaligned = misaligned_q;

    // Fetch FSM, PC, wrong-path drop flag, hold buffer and IF/ID register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_PC;
            req_pc_q         <= 32'd0;
            drop_q           <= 1'b0;
            hold_q           <= 32'd0;
            if_valid_q       <= 1'b0;
            if_instruction_q <= 32'd0;
            if_pc_q          <= 32'd0;
            misaligned_q     <= 1'b0;
        end else begin
            misaligned_q <= redirect_valid & (|redirect_pc[1:0]);

            if (redirect_valid) begin
                // Redirect wins over stall: flush IF/ID and any held word.
                pc_q       <= w_redirect_aligned;
                if_valid_q <= 1'b0;
                case (state_q)
                    S_REQ: begin
                        if (w_req_fire) begin
                            // The request just issued is wrong-path.
                            req_pc_q <= pc_q;
                            drop_q   <= 1'b1;
                            state_q  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem.imem_rsp_valid) begin
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        state_q <= S_REQ;
                    end
                    default: begin
                        state_q <= S_REQ;
                    end
                endcase
            end else begin
                // Consumed instruction retires unless something loads below.
                if (!stall) begin
                    if_valid_q <= 1'b0;
                end
                case (state_q)
                    S_REQ: begin
                        if (w_req_fire) begin
                            req_pc_q <= pc_q;
                            pc_q     <= w_pc_inc;
                            state_q  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem.imem_rsp_valid) begin
                            if (drop_q) begin
                                drop_q  <= 1'b0;
                                state_q <= S_REQ;
                            end else if (w_ifid_free) begin
                                if_valid_q       <= 1'b1;
                                if_instruction_q <= imem.imem_rsp_data;
                                if_pc_q          <= req_pc_q;
                                state_q          <= S_REQ;
                            end else begin
                                hold_q  <= imem.imem_rsp_data;
                                state_q <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            if_valid_q       <= 1'b1;
                            if_instruction_q <= hold_q;
                            if_pc_q          <= req_pc_q;
                            state_q          <= S_REQ;
                        end
                    end
                    default: begin
                        state_q <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch
//  Description : Directed, table-driven bench for inst_fetch with a simple
//                in-order instruction memory of programmable latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        fetch_misaligned;

    inst_fetch_if imem_bus ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .imem             (imem_bus),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_instruction   (if_instruction),
        .if_pc            (if_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Memory model state
    int          lat = 1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'd0;

    typedef struct {
        bit          ready;
        bit          stl;
        bit          rdv;
        logic [31:0] rdpc;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_v;
        logic [31:0] exp_pc;
        bit          exp_mis;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_cycle(input string tag, input bit rv, input logic [31:0] addr,
                                input bit v, input logic [31:0] pc);
        chk({tag, ".req_valid"}, {31'd0, imem_bus.imem_req_valid}, {31'd0, rv});
        chk({tag, ".req_addr"}, imem_bus.imem_req_addr, addr);
        chk({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".if_pc"}, if_pc, pc);
            chk({tag, ".if_instr"}, if_instruction, mem_word(pc));
        end
    endtask

    // One clock: note handshake, advance, then deliver any due response.
    task automatic step();
        logic        fired;
        logic [31:0] faddr;
        fired = imem_bus.imem_req_valid && imem_bus.imem_req_ready && reset_n;
        faddr = imem_bus.imem_req_addr;
        @(posedge clock);
        #1;
        if (fired) begin
            pend  = 1'b1;
            paddr = faddr;
            cnt   = lat;
        end
        imem_bus.imem_rsp_valid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_bus.imem_rsp_valid = 1'b1;
                imem_bus.imem_rsp_data  = mem_word(paddr);
                pend = 1'b0;
            end
        end
    endtask

    function automatic vec_t mk(bit ready, bit stl, bit rdv, logic [31:0] rdpc, bit rv,
                                logic [31:0] addr, bit v, logic [31:0] pc, bit mis);
        vec_t t;
        t.ready = ready; t.stl = stl; t.rdv = rdv; t.rdpc = rdpc;
        t.exp_rv = rv; t.exp_addr = addr; t.exp_v = v; t.exp_pc = pc; t.exp_mis = mis;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Sequential fetch, stall into HOLD, drop on redirect, misaligned redirect.
        vq.push_back(mk(1,0,0,0, 0,32'h004, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h004, 1,32'h0, 0));
        vq.push_back(mk(1,0,0,0, 0,32'h008, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h008, 1,32'h4, 0));
        vq.push_back(mk(1,1,0,0, 0,32'h00C, 1,32'h4, 0));
        vq.push_back(mk(1,1,0,0, 0,32'h00C, 1,32'h4, 0));
        vq.push_back(mk(1,1,0,0, 0,32'h00C, 1,32'h4, 0));
        vq.push_back(mk(1,1,0,0, 0,32'h00C, 1,32'h4, 0));
        vq.push_back(mk(1,1,0,0, 0,32'h00C, 1,32'h4, 0));
        vq.push_back(mk(1,0,0,0, 1,32'h00C, 1,32'h8, 0));
        vq.push_back(mk(1,0,0,0, 0,32'h010, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h010, 1,32'hC, 0));
        vq.push_back(mk(1,0,0,0, 0,32'h014, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h014, 1,32'h10,0));
        vq.push_back(mk(1,0,0,0, 0,32'h018, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h018, 1,32'h14,0));
        vq.push_back(mk(1,0,0,0, 0,32'h01C, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h01C, 1,32'h18,0));
        vq.push_back(mk(1,0,0,0, 0,32'h020, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h020, 1,32'h1C,0));
        vq.push_back(mk(1,0,1,32'h100, 0,32'h100, 0,0, 0));
        vq.push_back(mk(1,0,0,0, 1,32'h100, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 0,32'h104, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h104, 1,32'h100,0));
        vq.push_back(mk(0,0,1,32'h203, 1,32'h200, 0,0, 1));
        vq.push_back(mk(1,0,0,0, 0,32'h204, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h204, 1,32'h200,0));
        vq.push_back(mk(0,0,0,0, 1,32'h204, 0,0,     0));
        vq.push_back(mk(0,0,0,0, 1,32'h204, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 0,32'h208, 0,0,     0));
        vq.push_back(mk(1,0,0,0, 1,32'h208, 1,32'h204,0));

        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_bus.imem_req_ready = 1'b1;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        expect_cycle("reset", 1'b1, 32'h0, 1'b0, 32'h0);
        chk("reset.if_pc", if_pc, 32'h0);
        chk("reset.if_instr", if_instruction, 32'h0);
        chk("reset.misaligned", {31'd0, fetch_misaligned}, 32'd0);

        foreach (vq[i]) begin
            imem_bus.imem_req_ready = vq[i].ready;
            stall          = vq[i].stl;
            redirect_valid = vq[i].rdv;
            redirect_pc    = vq[i].rdpc;
            step();
            redirect_valid = 1'b0;
            expect_cycle($sformatf("v%0d", i), vq[i].exp_rv, vq[i].exp_addr,
                         vq[i].exp_v, vq[i].exp_pc);
            chk($sformatf("v%0d.misaligned", i), {31'd0, fetch_misaligned},
                {31'd0, vq[i].exp_mis});
        end

        // Redirect while waiting with no response yet: late word is dropped.
        imem_bus.imem_req_ready = 1'b1;
        lat = 3;
        step();
        expect_cycle("wr.fire", 1'b0, 32'h20C, 1'b0, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_valid = 1'b0;
        expect_cycle("wr.redir", 1'b0, 32'h300, 1'b0, 32'h0);
        step();
        expect_cycle("wr.wait", 1'b0, 32'h300, 1'b0, 32'h0);
        lat = 1;
        step();
        expect_cycle("wr.drop", 1'b1, 32'h300, 1'b0, 32'h0);
        step();
        step();
        expect_cycle("wr.next", 1'b1, 32'h304, 1'b1, 32'h300);

        // Redirect coinciding with a response: response discarded.
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        expect_cycle("wrsp.redir", 1'b1, 32'h400, 1'b0, 32'h0);
        step();
        step();
        expect_cycle("wrsp.next", 1'b1, 32'h404, 1'b1, 32'h400);

        // Redirect from HOLD overrides stall and discards the held word.
        stall = 1'b1;
        step();
        step();
        expect_cycle("hold.in", 1'b0, 32'h408, 1'b1, 32'h400);
        redirect_valid = 1'b1; redirect_pc = 32'h500;
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        expect_cycle("hold.redir", 1'b1, 32'h500, 1'b0, 32'h0);
        step();
        step();
        expect_cycle("hold.next", 1'b1, 32'h504, 1'b1, 32'h500);

        // PC wrap from the top of the address space.
        imem_bus.imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        expect_cycle("wrap.redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("wrap.misaligned", {31'd0, fetch_misaligned}, 32'd0);
        imem_bus.imem_req_ready = 1'b1;
        step();
        expect_cycle("wrap.fire", 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        expect_cycle("wrap.load", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);

        // Asynchronous reset during WAIT, then a late response is ignored.
        stall = 1'b1;
        lat = 2;
        step();
        expect_cycle("rst.wait", 1'b0, 32'h4, 1'b1, 32'hFFFF_FFFC);
        reset_n = 1'b0;
        #1;
        chk("rst.if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst.if_pc", if_pc, 32'h0);
        chk("rst.if_instr", if_instruction, 32'h0);
        chk("rst.req_addr", imem_bus.imem_req_addr, 32'h0);
        stall = 1'b0;
        imem_bus.imem_req_ready = 1'b0;
        step();
        reset_n = 1'b1;
        lat = 1;
        step();
        expect_cycle("rst.late", 1'b1, 32'h0, 1'b0, 32'h0);
        imem_bus.imem_req_ready = 1'b1;
        step();
        expect_cycle("rst.fire", 1'b0, 32'h4, 1'b0, 32'h0);
        step();
        expect_cycle("rst.load", 1'b1, 32'h4, 1'b1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
